// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU even-pipe issue logic.
package spu_pkg;

  localparam int SPU_NUM_UNITS = 4;
  localparam int SPU_MAX_LAT   = 7;
  localparam int REG_AW        = 7;

  typedef enum logic [1:0] {
    UNIT_SF1  = 2'd0,
    UNIT_SF2  = 2'd1,
    UNIT_SP   = 2'd2,
    UNIT_BYTE = 2'd3
  } unit_e;

  // Result latency of each unit, indexed by unit_e.
  localparam int UNIT_LAT [SPU_NUM_UNITS] = '{2, 4, 6, 4};

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rt_addr;
    unit_e             unit;
  } wb_slot_t;

endpackage

// File: rtl/wb_reservation_table.sv
// Writeback reservation table: slot k holds the result landing k cycles from now.
// Shifts every cycle, inserts new reservations and flags register/port hazards.
module wb_reservation_table
  import spu_pkg::*;
#(
  parameter int MAX_LAT = SPU_MAX_LAT,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ins_en,
  input  wb_slot_t              ins_slot,
  input  logic [LAT_W-1:0]      ins_lat,
  input  logic                  chk_wb,
  input  logic [3*REG_AW-1:0]   src_addr,
  input  logic [2:0]            src_use,
  output logic                  raw,
  output logic                  waw,
  output logic                  wbc,
  output wb_slot_t              slot0,
  output logic [3:0]            count
);

  wb_slot_t            slot_reg [MAX_LAT+1];
  logic [MAX_LAT:0]    raw_vec;
  logic [MAX_LAT:0]    waw_vec;
  logic [MAX_LAT:0]    wbc_vec;
  logic [3:0]          count_next;

  // The insert is written after the shift so it lands in its final position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= MAX_LAT; k++) begin
        slot_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MAX_LAT; k++) begin
        slot_reg[k] <= slot_reg[k+1];
      end
      slot_reg[MAX_LAT] <= '0;
      if (ins_en) begin
        slot_reg[ins_lat] <= ins_slot;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= MAX_LAT; gi++) begin : g_slot
      assign raw_vec[gi] = slot_reg[gi].valid && (
          (src_use[0] && slot_reg[gi].rt_addr == src_addr[0        +: REG_AW]) ||
          (src_use[1] && slot_reg[gi].rt_addr == src_addr[REG_AW   +: REG_AW]) ||
          (src_use[2] && slot_reg[gi].rt_addr == src_addr[2*REG_AW +: REG_AW]));
      assign waw_vec[gi] = slot_reg[gi].valid && (slot_reg[gi].rt_addr == ins_slot.rt_addr);
      // A valid entry one slot above the new latency would collide after the shift.
      if (gi == 0) begin : g_base
        assign wbc_vec[gi] = 1'b0;
      end else begin : g_upper
        assign wbc_vec[gi] = slot_reg[gi].valid && (ins_lat == LAT_W'(gi - 1));
      end
    end
  endgenerate

  always_comb begin
    count_next = '0;
    for (int k = 0; k <= MAX_LAT; k++) begin
      count_next = count_next + {3'b000, slot_reg[k].valid};
    end
  end

  assign raw   = |raw_vec;
  assign waw   = chk_wb & (|waw_vec);
  assign wbc   = chk_wb & (|wbc_vec);
  assign slot0 = slot_reg[0];
  assign count = count_next;

endmodule

// File: rtl/even_pipe_issue_ctrl.sv
// Even-pipe issue controller: hazard-checked acceptance, registered issue to one
// unit, and writeback-port steering from the reservation table.
module even_pipe_issue_ctrl
  import spu_pkg::*;
#(
  parameter int NUM_UNITS = SPU_NUM_UNITS,
  parameter int MAX_LAT   = SPU_MAX_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_unit,
  input  logic [10:0]           in_op,
  input  logic [2:0]            in_format,
  input  logic [17:0]           in_imm,
  input  logic [6:0]            in_rt_addr,
  input  logic                  in_reg_write,
  input  logic [20:0]           in_src_addr,
  input  logic [2:0]            in_src_use,
  input  logic                  flush,
  output logic                  iss_valid,
  output logic [NUM_UNITS-1:0]  iss_unit,
  output logic [10:0]           iss_op,
  output logic [2:0]            iss_format,
  output logic [17:0]           iss_imm,
  output logic [6:0]            iss_rt_addr,
  output logic                  iss_reg_write,
  output logic                  wb_valid,
  output logic [NUM_UNITS-1:0]  wb_unit,
  output logic [6:0]            wb_rt_addr,
  output logic [3:0]            inflight_cnt
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic [NUM_UNITS-1:0] unit_oh;
  logic                 unit_ok;
  logic                 reg_write_eff;
  logic [LAT_W-1:0]     lat;
  logic                 raw, waw, wbc;
  logic                 ready_core;
  logic                 accept;
  wb_slot_t             new_slot;
  wb_slot_t             slot0;

  logic                 iss_valid_reg;
  logic [NUM_UNITS-1:0] iss_unit_reg;
  logic [10:0]          iss_op_reg;
  logic [2:0]           iss_format_reg;
  logic [17:0]          iss_imm_reg;
  logic [6:0]           iss_rt_addr_reg;
  logic                 iss_reg_write_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign unit_oh[gi] = (32'(in_unit) == gi);
      assign wb_unit[gi] = slot0.valid && (32'(slot0.unit) == gi);
    end
  endgenerate

  // An unknown unit is issued as a nop: no reservation, no port hazards.
  assign unit_ok       = |unit_oh;
  assign reg_write_eff = in_reg_write & unit_ok;
  assign lat           = LAT_W'(UNIT_LAT[in_unit]);

  assign new_slot.valid   = 1'b1;
  assign new_slot.rt_addr = in_rt_addr;
  assign new_slot.unit    = unit_e'(in_unit);

  wb_reservation_table #(
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .ins_en   (accept & reg_write_eff),
    .ins_slot (new_slot),
    .ins_lat  (lat),
    .chk_wb   (reg_write_eff),
    .src_addr (in_src_addr),
    .src_use  (in_src_use),
    .raw      (raw),
    .waw      (waw),
    .wbc      (wbc),
    .slot0    (slot0),
    .count    (inflight_cnt)
  );

  // Reset only gates the visible handshake; all state is held clear while it is low.
  assign ready_core = ~flush & ~raw & ~waw & ~wbc;
  assign in_ready   = reset & ready_core;
  assign accept     = in_valid & ready_core;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_valid_reg     <= 1'b0;
      iss_unit_reg      <= '0;
      iss_op_reg        <= '0;
      iss_format_reg    <= '0;
      iss_imm_reg       <= '0;
      iss_rt_addr_reg   <= '0;
      iss_reg_write_reg <= 1'b0;
    end else begin
      iss_valid_reg <= accept;
      if (accept) begin
        iss_unit_reg      <= unit_oh;
        iss_op_reg        <= in_op;
        iss_format_reg    <= in_format;
        iss_imm_reg       <= in_imm;
        iss_rt_addr_reg   <= in_rt_addr;
        iss_reg_write_reg <= in_reg_write;
      end
    end
  end

  assign iss_valid     = iss_valid_reg;
  assign iss_unit      = iss_unit_reg;
  assign iss_op        = iss_op_reg;
  assign iss_format    = iss_format_reg;
  assign iss_imm       = iss_imm_reg;
  assign iss_rt_addr   = iss_rt_addr_reg;
  assign iss_reg_write = iss_reg_write_reg;

  assign wb_valid   = slot0.valid;
  assign wb_rt_addr = slot0.rt_addr;

endmodule
